// File: rtl/random_math_engine.sv
// ---------------------------------------------------------------------------
// random_math_engine
//
// Interpreter for CryptoNight-R random-math programs. A run loads NUM_REGS
// registers of DATA_W bits from in_regs, then streams instructions out of a
// synchronous program RAM and retires one per cycle until RET or a fault.
// The register file stays on out_regs until the next accepted start.
//
// Instruction word on prog_rdata: {op[7:0], dst[7:0], src[7:0], imm[DATA_W-1:0]}
//   op 0 MUL  r[dst] = low(r[dst] * r[src])
//   op 1 ADD  r[dst] = r[dst] + r[src] + imm
//   op 2 SUB  r[dst] = r[dst] - r[src]
//   op 3 ROR  r[dst] = r[dst] rotated right by r[src] & (DATA_W-1)
//   op 4 ROL  r[dst] = r[dst] rotated left  by r[src] & (DATA_W-1)
//   op 5 XOR  r[dst] = r[dst] ^ r[src]
//   op 6 RET  end of program
//   other     bad opcode
//
// Ports
//   clk, reset   clock, asynchronous active-high reset
//   start        begin a run; only looked at while idle
//   in_regs      initial register file, reg i at [i*DATA_W +: DATA_W]
//   prog_addr    program RAM read address (data returns one cycle later)
//   prog_rdata   program RAM read data
//   busy         run in progress (fill and execute phases)
//   done         one-cycle pulse when a run ends (RET or fault)
//   error        last run aborted; held until the next accepted start
//   err_code     0 none, 1 bad opcode, 2 register index out of range,
//                3 ran off the end of program memory
//   insn_count   instructions retired in the current/last run (RET excluded)
//   out_regs     live register file, same packing as in_regs
//   fsm_state    controller state: 0 idle, 1 fill, 2 exec, 3 done
//
// Handshake: start is a level; it is accepted on a rising clock edge while
// the controller is idle and is ignored in every other state. There is no
// back-pressure on the program RAM: an address issued on prog_addr must be
// answered on prog_rdata on the following cycle.
// ---------------------------------------------------------------------------
module random_math_engine #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 9,
   parameter int ADDR_W   = 7
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [NUM_REGS*DATA_W-1:0] in_regs,
   output logic [ADDR_W-1:0]          prog_addr,
   input  logic [DATA_W+23:0]         prog_rdata,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic [1:0]                 err_code,
   output logic [ADDR_W:0]            insn_count,
   output logic [NUM_REGS*DATA_W-1:0] out_regs,
   output logic [1:0]                 fsm_state
);

   localparam int IDX_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
   localparam int SH_W  = $clog2(DATA_W);

   localparam logic [8:0]        REG_LIMIT = 9'(NUM_REGS);
   localparam logic [SH_W:0]     WIDTH_L   = (SH_W+1)'(DATA_W);
   localparam logic [ADDR_W-1:0] LAST_PC   = '1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FILL = 2'd1;
   localparam logic [1:0] S_EXEC = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [7:0] OP_MUL = 8'd0;
   localparam logic [7:0] OP_ADD = 8'd1;
   localparam logic [7:0] OP_SUB = 8'd2;
   localparam logic [7:0] OP_ROR = 8'd3;
   localparam logic [7:0] OP_ROL = 8'd4;
   localparam logic [7:0] OP_XOR = 8'd5;
   localparam logic [7:0] OP_RET = 8'd6;

   logic [1:0] state;
   logic [1:0] state_next;

   logic [DATA_W-1:0] regs [NUM_REGS];

   // ---------------- instruction decode ----------------
   logic [7:0]        op;
   logic [7:0]        dst;
   logic [7:0]        src;
   logic [DATA_W-1:0] imm;
   logic [IDX_W-1:0]  dst_i;
   logic [IDX_W-1:0]  src_i;
   logic [ADDR_W-1:0] pc;

   assign op    = prog_rdata[DATA_W+23 -: 8];
   assign dst   = prog_rdata[DATA_W+15 -: 8];
   assign src   = prog_rdata[DATA_W+7 -: 8];
   assign imm   = prog_rdata[DATA_W-1:0];
   assign dst_i = dst[IDX_W-1:0];
   assign src_i = src[IDX_W-1:0];

   // prog_addr already points one ahead of the word on prog_rdata.
   assign pc = prog_addr - ADDR_W'(1);

   logic is_ret;
   logic bad_op;
   logic bad_idx;
   logic overrun;
   logic do_write;
   logic term;

   assign is_ret  = (op == OP_RET);
   assign bad_op  = (op > OP_RET);
   // RET carries no operands, so its index fields are don't-care.
   assign bad_idx = !bad_op && !is_ret &&
                    (({1'b0, dst} >= REG_LIMIT) || ({1'b0, src} >= REG_LIMIT));
   // The word at the last address still executes; the run then stops
   // because there is nothing valid to fetch after it.
   assign overrun  = !bad_op && !bad_idx && !is_ret && (pc == LAST_PC);
   assign do_write = !bad_op && !bad_idx && !is_ret;
   assign term     = is_ret || bad_op || bad_idx || overrun;

   // ---------------- execute ----------------
   // Operands come straight from the register array, so a write from the
   // previous cycle is already visible: no forwarding is needed.
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [SH_W-1:0]   amt;
   logic [SH_W:0]     amt_inv;
   logic [DATA_W-1:0] mul_r;
   logic [DATA_W-1:0] ror_r;
   logic [DATA_W-1:0] rol_r;
   logic [DATA_W-1:0] result;

   assign a       = regs[dst_i];
   assign b       = regs[src_i];
   assign amt     = b[SH_W-1:0];
   assign amt_inv = WIDTH_L - {1'b0, amt};
   assign mul_r   = a * b;
   // For amt == 0 the complementary shift is by DATA_W, which yields zero,
   // so the rotate degenerates cleanly to a pass-through.
   assign ror_r   = (a >> amt) | (a << amt_inv);
   assign rol_r   = (a << amt) | (a >> amt_inv);

   always_comb begin
      result = a;
      case (op)
         OP_MUL:  result = mul_r;
         OP_ADD:  result = a + b + imm;
         OP_SUB:  result = a - b;
         OP_ROR:  result = ror_r;
         OP_ROL:  result = rol_r;
         OP_XOR:  result = a ^ b;
         default: result = a;
      endcase
   end

   // ---------------- controller ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_FILL;
         S_FILL:  state_next = S_EXEC;
         S_EXEC:  if (term) state_next = S_DONE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == S_FILL) || (state == S_EXEC);
      done      = (state == S_DONE);
      fsm_state = state;
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         prog_addr  <= '0;
         error      <= 1'b0;
         err_code   <= 2'd0;
         insn_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                     regs[i] <= in_regs[i*DATA_W +: DATA_W];
                  end
                  prog_addr  <= '0;
                  error      <= 1'b0;
                  err_code   <= 2'd0;
                  insn_count <= '0;
               end
            end
            S_FILL: begin
               prog_addr <= ADDR_W'(1);
            end
            S_EXEC: begin
               if (do_write) begin
                  regs[dst_i] <= result;
                  insn_count  <= insn_count + (ADDR_W+1)'(1);
               end
               if (!term) begin
                  prog_addr <= prog_addr + ADDR_W'(1);
               end
               if (bad_op) begin
                  error    <= 1'b1;
                  err_code <= 2'd1;
               end else if (bad_idx) begin
                  error    <= 1'b1;
                  err_code <= 2'd2;
               end else if (overrun) begin
                  error    <= 1'b1;
                  err_code <= 2'd3;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      out_regs = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         out_regs[i*DATA_W +: DATA_W] = regs[i];
      end
   end

endmodule

// File: tb/tb_random_math_engine.sv
`timescale 1ns/1ps
module tb_random_math_engine;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   int total = 0;
   int bad   = 0;

   // ---------------- DUT 0: default parameters ----------------
   logic         start0;
   logic [287:0] in0;
   logic [6:0]   addr0;
   logic [55:0]  rdata0;
   logic         busy0, done0, err0;
   logic [1:0]   code0, st0;
   logic [7:0]   cnt0;
   logic [287:0] out0;
   logic [55:0]  mem0 [128];

   always @(posedge clk) rdata0 <= mem0[addr0];

   random_math_engine dut0 (
      .clk(clk), .reset(reset), .start(start0), .in_regs(in0),
      .prog_addr(addr0), .prog_rdata(rdata0), .busy(busy0), .done(done0),
      .error(err0), .err_code(code0), .insn_count(cnt0), .out_regs(out0),
      .fsm_state(st0)
   );

   // ---------------- DUT 1: 64-bit, 4 regs, 16-word program ----------------
   logic         start1;
   logic [255:0] in1;
   logic [3:0]   addr1;
   logic [87:0]  rdata1;
   logic         busy1, done1, err1;
   logic [1:0]   code1, st1;
   logic [4:0]   cnt1;
   logic [255:0] out1;
   logic [87:0]  mem1 [16];

   always @(posedge clk) rdata1 <= mem1[addr1];

   random_math_engine #(.DATA_W(64), .NUM_REGS(4), .ADDR_W(4)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .in_regs(in1),
      .prog_addr(addr1), .prog_rdata(rdata1), .busy(busy1), .done(done1),
      .error(err1), .err_code(code1), .insn_count(cnt1), .out_regs(out1),
      .fsm_state(st1)
   );

   // ---------------- helpers (stimulus only) ----------------
   function automatic logic [55:0] i32(input logic [7:0] op, input logic [7:0] dst,
                                       input logic [7:0] src, input logic [31:0] imm);
      return {op, dst, src, imm};
   endfunction

   function automatic logic [87:0] i64(input logic [7:0] op, input logic [7:0] dst,
                                       input logic [7:0] src, input logic [63:0] imm);
      return {op, dst, src, imm};
   endfunction

   function automatic logic [31:0] g0(input int i);
      return out0[i*32 +: 32];
   endfunction

   function automatic logic [63:0] g1(input int i);
      return out1[i*64 +: 64];
   endfunction

   task automatic clear0();
      for (int i = 0; i < 128; i++) mem0[i] = i32(8'd6, 8'd0, 8'd0, 32'd0);
   endtask

   task automatic clear1();
      for (int i = 0; i < 16; i++) mem1[i] = i64(8'd6, 8'd0, 8'd0, 64'd0);
   endtask

   // Start a run on DUT 0 and return the cycle index (start cycle = 0) at
   // which done is seen. Returns positioned in the done cycle.
   task automatic run0(output int cyc);
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0; cyc = 1;
      while (done0 !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
      total++;
      if (done0 !== 1'b1) begin bad++; $display("FAIL run0_timeout got=%0d cycles required=done pulse", cyc); end
   endtask

   task automatic run1(output int cyc);
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0; cyc = 1;
      while (done1 !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
      total++;
      if (done1 !== 1'b1) begin bad++; $display("FAIL run1_timeout got=%0d cycles required=done pulse", cyc); end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int n;
      int dn;
      reset = 1'b1; start0 = 1'b0; start1 = 1'b0; in0 = '0; in1 = '0;
      clear0(); clear1();
      repeat (3) @(negedge clk);
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy0); end
      total++; if (done0 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done0); end
      total++; if (addr0 !== 7'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", addr0); end
      total++; if ({err0, code0, cnt0} !== 11'd0) begin bad++; $display("FAIL reset_status got=%h exp=0", {err0, code0, cnt0}); end
      total++; if (out0 !== 288'd0) begin bad++; $display("FAIL reset_regs got=%h exp=0", out0); end
      total++; if (st0 !== 2'd0 || out1 !== 256'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", st0); end
      reset = 1'b0;

      // abort mid-run
      for (int i = 0; i < 20; i++) mem0[i] = i32(8'd1, 8'd0, 8'd1, 32'd1);
      in0[0*32 +: 32] = 32'd5; in0[1*32 +: 32] = 32'd2;
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      n = 0;
      while (addr0 !== 7'd5 && n < 50) begin @(negedge clk); n++; end
      total++; if (addr0 !== 7'd5) begin bad++; $display("FAIL midrun_reach got=%0d exp=5", addr0); end
      total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL midrun_busy got=%b exp=1", busy0); end
      reset = 1'b1; #1;
      total++; if (busy0 !== 1'b0 || addr0 !== 7'd0) begin bad++; $display("FAIL abort_busy_addr got=%b/%0d exp=0/0", busy0, addr0); end
      total++; if (out0 !== 288'd0 || cnt0 !== 8'd0) begin bad++; $display("FAIL abort_regs got cnt=%0d exp=0", cnt0); end
      dn = 0;
      @(negedge clk); if (done0 !== 1'b0) dn++;
      reset = 1'b0;
      repeat (4) begin @(negedge clk); if (done0 !== 1'b0) dn++; end
      total++; if (dn != 0) begin bad++; $display("FAIL abort_no_done got=%0d pulses exp=0", dn); end
      total++; if (st0 !== 2'd0 || err0 !== 1'b0) begin bad++; $display("FAIL abort_idle got=%0d exp=0", st0); end
   endtask

   task automatic test_arith();
      int cyc;
      clear0();
      mem0[0] = i32(8'd0, 8'd0, 8'd1, 32'd0);      // MUL r0,r1
      mem0[1] = i32(8'd1, 8'd0, 8'd1, 32'h10);     // ADD r0,r1,0x10
      mem0[2] = i32(8'd2, 8'd1, 8'd0, 32'd0);      // SUB r1,r0
      in0 = '0;
      in0[0*32 +: 32] = 32'd7; in0[1*32 +: 32] = 32'd3; in0[2*32 +: 32] = 32'hA5A5A5A5;
      run0(cyc);
      total++; if (cyc != 6) begin bad++; $display("FAIL arith_latency got=%0d exp=6", cyc); end
      total++; if (g0(0) !== 32'h28) begin bad++; $display("FAIL arith_r0 got=%h exp=28", g0(0)); end
      total++; if (g0(1) !== 32'hFFFFFFDB) begin bad++; $display("FAIL arith_r1 got=%h exp=ffffffdb", g0(1)); end
      total++; if (g0(2) !== 32'hA5A5A5A5) begin bad++; $display("FAIL arith_r2 got=%h exp=a5a5a5a5", g0(2)); end
      total++; if (cnt0 !== 8'd3) begin bad++; $display("FAIL arith_count got=%0d exp=3", cnt0); end
      total++; if (err0 !== 1'b0 || code0 !== 2'd0 || busy0 !== 1'b0) begin bad++; $display("FAIL arith_status got=%b%0d%b exp=000", err0, code0, busy0); end
      @(negedge clk);
      total++; if (done0 !== 1'b0) begin bad++; $display("FAIL arith_done_pulse got=%b exp=0", done0); end
      total++; if (g0(0) !== 32'h28 || st0 !== 2'd0) begin bad++; $display("FAIL arith_hold got=%h exp=28", g0(0)); end
   endtask

   task automatic test_rotate();
      int cyc;
      clear0();
      mem0[0] = i32(8'd3, 8'd8, 8'd3, 32'd0);      // ROR r8,r3 (by 0)
      mem0[1] = i32(8'd3, 8'd2, 8'd3, 32'd0);      // ROR r2,r3 (by 0)
      mem0[2] = i32(8'd1, 8'd3, 8'd3, 32'd33);     // ADD r3,r3,33
      mem0[3] = i32(8'd4, 8'd2, 8'd3, 32'd0);      // ROL r2,r3 (33 -> 1)
      mem0[4] = i32(8'd4, 8'd2, 8'd3, 32'd0);      // ROL r2,r3
      mem0[5] = i32(8'd3, 8'd4, 8'd5, 32'd0);      // ROR r4,r5 (31)
      mem0[6] = i32(8'd4, 8'd6, 8'd5, 32'd0);      // ROL r6,r5 (31)
      mem0[7] = i32(8'd5, 8'd7, 8'd7, 32'd0);      // XOR r7,r7
      in0 = '0;
      in0[2*32 +: 32] = 32'h80000001; in0[4*32 +: 32] = 32'h80000001;
      in0[5*32 +: 32] = 32'd31;       in0[6*32 +: 32] = 32'h12345678;
      in0[7*32 +: 32] = 32'hDEADBEEF; in0[8*32 +: 32] = 32'h80000001;
      run0(cyc);
      total++; if (cyc != 11) begin bad++; $display("FAIL rot_latency got=%0d exp=11", cyc); end
      total++; if (g0(8) !== 32'h80000001) begin bad++; $display("FAIL ror_by0 got=%h exp=80000001", g0(8)); end
      total++; if (g0(3) !== 32'd33) begin bad++; $display("FAIL rot_r3 got=%h exp=21", g0(3)); end
      total++; if (g0(2) !== 32'h00000006) begin bad++; $display("FAIL rol_by33 got=%h exp=00000006", g0(2)); end
      total++; if (g0(4) !== 32'h00000003) begin bad++; $display("FAIL ror_by31 got=%h exp=00000003", g0(4)); end
      total++; if (g0(6) !== 32'h091A2B3C) begin bad++; $display("FAIL rol_by31 got=%h exp=091a2b3c", g0(6)); end
      total++; if (g0(7) !== 32'd0) begin bad++; $display("FAIL xor_self got=%h exp=0", g0(7)); end
      total++; if (cnt0 !== 8'd8) begin bad++; $display("FAIL rot_count got=%0d exp=8", cnt0); end
   endtask

   task automatic test_errors();
      int cyc;
      // bad opcode at pc 2
      clear0();
      mem0[0] = i32(8'd1, 8'd0, 8'd1, 32'd1);      // ADD r0,r1,1 -> 31
      mem0[1] = i32(8'd5, 8'd2, 8'd3, 32'd0);      // XOR r2,r3 -> 3
      mem0[2] = i32(8'h09, 8'd0, 8'd1, 32'd0);     // bad opcode
      in0 = '0;
      in0[0*32 +: 32] = 32'd10; in0[1*32 +: 32] = 32'd20;
      in0[2*32 +: 32] = 32'd5;  in0[3*32 +: 32] = 32'd6; in0[8*32 +: 32] = 32'h77;
      run0(cyc);
      total++; if (cyc != 5) begin bad++; $display("FAIL badop_latency got=%0d exp=5", cyc); end
      total++; if (err0 !== 1'b1 || code0 !== 2'd1) begin bad++; $display("FAIL badop_code got=%b/%0d exp=1/1", err0, code0); end
      total++; if (cnt0 !== 8'd2) begin bad++; $display("FAIL badop_count got=%0d exp=2", cnt0); end
      total++; if (g0(0) !== 32'd31 || g0(1) !== 32'd20 || g0(2) !== 32'd3) begin bad++; $display("FAIL badop_regs got=%h/%h/%h exp=1f/14/3", g0(0), g0(1), g0(2)); end
      @(negedge clk);
      total++; if (err0 !== 1'b1 || code0 !== 2'd1) begin bad++; $display("FAIL badop_hold got=%b/%0d exp=1/1", err0, code0); end

      // dst = 9 after a valid write to r8 (the highest legal index)
      clear0();
      mem0[0] = i32(8'd5, 8'd8, 8'd0, 32'd0);      // XOR r8,r0 -> 0x7d
      mem0[1] = i32(8'd1, 8'd9, 8'd0, 32'd0);      // ADD r9,r0 -> index fault
      run0(cyc);
      total++; if (err0 !== 1'b1 || code0 !== 2'd2) begin bad++; $display("FAIL idx_dst_code got=%b/%0d exp=1/2", err0, code0); end
      total++; if (cnt0 !== 8'd1 || g0(8) !== 32'h7D || g0(0) !== 32'd10) begin bad++; $display("FAIL idx_dst_state got cnt=%0d r8=%h exp=1/7d", cnt0, g0(8)); end

      // src = 255
      clear0();
      mem0[0] = i32(8'd2, 8'd0, 8'd255, 32'd0);
      run0(cyc);
      total++; if (code0 !== 2'd2 || cnt0 !== 8'd0 || g0(0) !== 32'd10) begin bad++; $display("FAIL idx_src got code=%0d cnt=%0d exp=2/0", code0, cnt0); end

      // RET with out-of-range indices is fine, and start clears the old error
      clear0();
      mem0[0] = i32(8'd6, 8'd200, 8'd255, 32'd0);
      run0(cyc);
      total++; if (cyc != 3) begin bad++; $display("FAIL ret_only_latency got=%0d exp=3", cyc); end
      total++; if (err0 !== 1'b0 || code0 !== 2'd0 || cnt0 !== 8'd0) begin bad++; $display("FAIL ret_indices got=%b/%0d/%0d exp=0/0/0", err0, code0, cnt0); end

      // no RET anywhere: every word retires, then overrun
      for (int i = 0; i < 128; i++) mem0[i] = i32(8'd1, 8'd0, 8'd1, 32'd1);
      in0 = '0;
      run0(cyc);
      total++; if (cyc != 130) begin bad++; $display("FAIL overrun_latency got=%0d exp=130", cyc); end
      total++; if (err0 !== 1'b1 || code0 !== 2'd3) begin bad++; $display("FAIL overrun_code got=%b/%0d exp=1/3", err0, code0); end
      total++; if (cnt0 !== 8'd128 || g0(0) !== 32'd128) begin bad++; $display("FAIL overrun_count got=%0d r0=%0d exp=128/128", cnt0, g0(0)); end
   endtask

   task automatic test_params();
      int cyc;
      clear1();
      mem1[0] = i64(8'd1, 8'd0, 8'd2, 64'hFFFFFFFF_FFFFFFFF); // ADD r0,r2,-1
      mem1[1] = i64(8'd5, 8'd1, 8'd1, 64'd0);                 // XOR r1,r1
      mem1[2] = i64(8'd0, 8'd3, 8'd3, 64'd0);                 // MUL r3,r3
      mem1[3] = i64(8'd3, 8'd3, 8'd3, 64'd0);                 // ROR r3,r3 (by 1)
      in1 = '0;
      in1[0*64 +: 64] = 64'd1;
      in1[1*64 +: 64] = 64'h01234567_89ABCDEF;
      in1[3*64 +: 64] = 64'h00000001_00000001;
      run1(cyc);
      total++; if (cyc != 7) begin bad++; $display("FAIL p64_latency got=%0d exp=7", cyc); end
      total++; if (g1(0) !== 64'd0) begin bad++; $display("FAIL p64_add_wrap got=%h exp=0", g1(0)); end
      total++; if (g1(1) !== 64'd0) begin bad++; $display("FAIL p64_xor_self got=%h exp=0", g1(1)); end
      total++; if (g1(3) !== 64'h80000001_00000000) begin bad++; $display("FAIL p64_mul_ror got=%h exp=8000000100000000", g1(3)); end
      total++; if (cnt1 !== 5'd4 || err1 !== 1'b0) begin bad++; $display("FAIL p64_count got=%0d exp=4", cnt1); end

      clear1();
      mem1[0] = i64(8'd0, 8'd4, 8'd0, 64'd0);                 // dst 4 of 4 regs
      run1(cyc);
      total++; if (code1 !== 2'd2 || cnt1 !== 5'd0 || cyc != 3) begin bad++; $display("FAIL p64_idx got code=%0d cnt=%0d cyc=%0d exp=2/0/3", code1, cnt1, cyc); end

      for (int i = 0; i < 16; i++) mem1[i] = i64(8'd1, 8'd0, 8'd2, 64'd1);
      in1 = '0; in1[2*64 +: 64] = 64'd5;
      run1(cyc);
      total++; if (err1 !== 1'b1 || code1 !== 2'd3 || cnt1 !== 5'd16) begin bad++; $display("FAIL p64_overrun got=%b/%0d/%0d exp=1/3/16", err1, code1, cnt1); end
      total++; if (g1(0) !== 64'd96 || cyc != 18) begin bad++; $display("FAIL p64_overrun_r0 got=%0d cyc=%0d exp=96/18", g1(0), cyc); end
   endtask

   task automatic test_back_to_back();
      int dc;
      int n;
      // start held high: a fresh run only from each IDLE visit
      clear0();
      mem0[0] = i32(8'd1, 8'd0, 8'd0, 32'd1);
      in0 = '0;
      @(negedge clk); start0 = 1'b1;
      dc = 0;
      for (int k = 0; k < 40; k++) begin
         if (done0 === 1'b1) dc++;
         @(negedge clk);
      end
      start0 = 1'b0;
      total++; if (dc != 8) begin bad++; $display("FAIL held_start_runs got=%0d exp=8", dc); end
      n = 0;
      while (st0 !== 2'd0 && n < 20) begin @(negedge clk); n++; end
      total++; if (st0 !== 2'd0) begin bad++; $display("FAIL held_start_idle got=%0d exp=0", st0); end

      // error run, then restart in the IDLE cycle right after done
      mem0[0] = i32(8'h09, 8'd0, 8'd0, 32'd0);
      in0 = '0; in0[0*32 +: 32] = 32'h11;
      run0(n);
      total++; if (code0 !== 2'd1) begin bad++; $display("FAIL b2b_first_code got=%0d exp=1", code0); end
      mem0[0] = i32(8'd6, 8'd0, 8'd0, 32'd0);
      in0[0*32 +: 32] = 32'h22;
      start0 = 1'b1;
      @(negedge clk);
      total++; if (st0 !== 2'd0 || err0 !== 1'b1) begin bad++; $display("FAIL b2b_idle got st=%0d err=%b exp=0/1", st0, err0); end
      @(negedge clk); start0 = 1'b0;
      total++; if (st0 !== 2'd1 || busy0 !== 1'b1) begin bad++; $display("FAIL b2b_fill got st=%0d busy=%b exp=1/1", st0, busy0); end
      total++; if (err0 !== 1'b0 || code0 !== 2'd0 || g0(0) !== 32'h22) begin bad++; $display("FAIL b2b_reload got err=%b r0=%h exp=0/22", err0, g0(0)); end
      n = 0;
      while (done0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      total++; if (done0 !== 1'b1 || n != 2 || err0 !== 1'b0 || cnt0 !== 8'd0) begin bad++; $display("FAIL b2b_done got n=%0d err=%b exp=2/0", n, err0); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_arith();
      test_rotate();
      test_errors();
      test_params();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
